// File: rtl/hazard_issue_seq_pkg.sv
// Shared constants for the 8-bit RISC issue path: opcodes, registers, hazard record layout.
package risc8_pkg;

  localparam logic [1:0] LW   = 2'b11;
  localparam logic [1:0] SW   = 2'b10;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] NOOP = 2'b00;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam logic [1:0] HAZ_TAG_VALID = 2'b01;

  // Record byte is {src[2:0], dst[2:0], tag[1:0]}
  localparam int REC_W       = 8;
  localparam int REC_SRC_LSB = 5;
  localparam int REC_DST_LSB = 2;
  localparam int REC_TAG_LSB = 0;

  localparam logic [7:0] NOP_INSTR   = 8'h00;
  localparam int         DEFAULT_GAP = 3;

  // Byte idx of a 64-bit packet, index 0 in the top byte
  function automatic logic [7:0] field8(input logic [63:0] bits, input logic [2:0] idx);
    return bits[8*(7-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/hazard_issue_seq_if.sv
// Issue-slot handshake between the sequencer (master) and the pipeline fetch (slave).
interface hazard_issue_seq_if;
  logic [7:0] out_instr;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_instr, output out_valid, input out_ready);
  modport slave  (input out_instr, input out_valid, output out_ready);
endinterface

// File: rtl/hazard_issue_seq_matrix.sv
// Unpacks the eight hazard records into dep[consumer][producer], dropping empty or backward records.
module hazard_matrix
  import risc8_pkg::*;
(
  input  logic [63:0]          hazard_bits,
  output logic [7:0][7:0]      dep
);

  logic [7:0] rec;
  logic [2:0] src;
  logic [2:0] dst;
  logic [1:0] tag;

  always_comb begin
    dep = '0;
    rec = '0;
    src = '0;
    dst = '0;
    tag = '0;
    for (int k = 0; k < 8; k++) begin
      rec = hazard_bits[REC_W*(7-k) +: REC_W];
      src = rec[REC_SRC_LSB +: 3];
      dst = rec[REC_DST_LSB +: 3];
      tag = rec[REC_TAG_LSB +: 2];
      // A consumer can only depend on an earlier producer
      if (tag == HAZ_TAG_VALID && dst > src) dep[dst][src] = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_issue_seq.sv
// Issues an 8-instruction packet one slot at a time, inserting NOP bubbles to honour hazard gaps.
// Optional macro HAZ_FORWARD_EN: EX/MEM forwarding, only lw producers stall (gap 2).
module hazard_issue_seq
  import risc8_pkg::*;
#(
  parameter int N_INSTR = 8,
  parameter int GAP     = DEFAULT_GAP,
  parameter int SLOT_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [63:0]         instr_bits,
  input  logic [63:0]         hazard_bits,
  hazard_issue_seq_if.master  iss,
  output logic                busy,
  output logic                done,
  output logic [SLOT_W-1:0]   bubble_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_BUBBLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                   state, state_nxt;
  logic [63:0]                  instr_q, hazard_q;
  logic [3:0]                   j, j_nxt;
  logic [SLOT_W-1:0]            slot_cnt, slot_nxt;
  logic [SLOT_W-1:0]            ts     [N_INSTR];
  logic [SLOT_W-1:0]            ts_nxt [N_INSTR];
  logic [N_INSTR-1:0][N_INSTR-1:0] dep;
  logic                         fire;
  logic                         ready_nxt;
  logic                         launch;
  logic [SLOT_W:0]              need;
`ifdef HAZ_FORWARD_EN
  logic [1:0]                   opc;
`endif

  hazard_matrix u_matrix (
    .hazard_bits (hazard_q),
    .dep         (dep)
  );

  assign launch        = (state == S_IDLE) && start;
  assign iss.out_valid = (state == S_ISSUE) || (state == S_BUBBLE);
  assign iss.out_instr = (state == S_ISSUE) ? field8(instr_q, j[2:0]) : NOP_INSTR;
  assign fire          = iss.out_valid && iss.out_ready;
  assign busy          = (state == S_LOAD) || (state == S_ISSUE) || (state == S_BUBBLE);
  assign done          = (state == S_DONE);

  // Decide the next slot from the post-handshake counters so the choice is ready by the next edge
  always_comb begin
    j_nxt     = j;
    slot_nxt  = slot_cnt;
    ts_nxt    = ts;
    ready_nxt = 1'b1;
    need      = '0;
`ifdef HAZ_FORWARD_EN
    opc       = '0;
`endif
    if (fire) begin
      slot_nxt = slot_cnt + 1'b1;
      if (state == S_ISSUE) begin
        ts_nxt[j[2:0]] = slot_cnt;
        j_nxt          = j + 4'd1;
      end
    end
    for (int i = 0; i < N_INSTR; i++) begin
`ifdef HAZ_FORWARD_EN
      opc  = instr_q[8*(7-i)+6 +: 2];
      need = {1'b0, ts_nxt[i]} + ((opc == LW) ? (SLOT_W+1)'(2) : (SLOT_W+1)'(1));
`else
      need = {1'b0, ts_nxt[i]} + (SLOT_W+1)'(GAP);
`endif
      if (dep[j_nxt[2:0]][i] && ({1'b0, slot_nxt} < need)) ready_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = ready_nxt ? S_ISSUE : S_BUBBLE;
      S_ISSUE,
      S_BUBBLE: begin
        if (fire) begin
          if (j_nxt == 4'(N_INSTR)) state_nxt = S_DONE;
          else                      state_nxt = ready_nxt ? S_ISSUE : S_BUBBLE;
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      j          <= '0;
      slot_cnt   <= '0;
      bubble_cnt <= '0;
      for (int i = 0; i < N_INSTR; i++) ts[i] <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        j          <= '0;
        slot_cnt   <= '0;
        bubble_cnt <= '0;
        for (int i = 0; i < N_INSTR; i++) ts[i] <= '0;
      end else begin
        j        <= j_nxt;
        slot_cnt <= slot_nxt;
        ts       <= ts_nxt;
        if (fire && state == S_BUBBLE) bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

  // Packet capture: data path only, no reset
  always_ff @(posedge clk) begin
    if (launch) begin
      instr_q  <= instr_bits;
      hazard_q <= hazard_bits;
    end
  end

endmodule

// File: doc/hazard_issue_seq.md
Name: hazard_issue_seq

Overview:
- Downstream of the hazard checker. Takes the 8-instruction packet (64 bits) and the checker's 64-bit hazard record list.
- Issues one 8-bit instruction per slot into the 5-stage pipeline fetch.
- Inserts NOP bubbles (8'h00) so that every flagged consumer issues at least GAP slots after its producer.
- Output uses a valid/ready handshake so the pipeline can back-pressure.

Parameters:
- N_INSTR, 8, instructions per packet; fixed by the 64-bit packet width.
- GAP, 3, minimum slot distance between a producer and its dependent consumer (no-forward pipeline).
- SLOT_W, 5, width of the slot counter and timestamps; must hold N_INSTR*GAP.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle pulse; latch packet and hazard list.
- instr_bits  in  64  instruction i at [63-8i -: 8]; opcode [7:6], fields [5:3], [2:0].
- hazard_bits  in  64  eight 8-bit records {src[2:0], dst[2:0], tag[1:0]}. tag 2'b01 = valid; any other tag = empty.
- out_instr  out  8  issued instruction or NOP.
- out_valid  out  1  out_instr valid.
- out_ready  in  1  pipeline accepts this cycle.
- busy  out  1  packet in flight.
- done  out  1  one-cycle pulse after the last instruction is accepted.
- bubble_cnt  out  SLOT_W  NOPs inserted in current/last packet.

Behaviour:
- Reset: state IDLE. out_instr=0, out_valid=0, busy=0, done=0, bubble_cnt=0. Slot counter and all timestamps = 0. Reset mid-packet aborts it; nothing further is issued.
- FSM IDLE -> LOAD -> ISSUE <-> BUBBLE -> DONE -> IDLE.
- IDLE: on start, register instr_bits and hazard_bits, set busy=1, clear bubble_cnt, go to LOAD. start in any other state is ignored.
- LOAD (1 cycle): build the 8x8 dependency matrix dep[j][i] from valid records. A record is discarded if dst<=src.
- ISSUE, for next index j:
  - ready_j holds when, for every i with dep[j][i], slot_cnt >= ts[i]+GAP.
  - If ready_j: present instruction j.
  - Else: go to BUBBLE and present 8'h00.
- First out_valid is asserted 2 cycles after start.
- Handshake:
  - out_instr/out_valid hold stable while out_ready=0.
  - A slot is consumed only on out_valid & out_ready; slot_cnt then increments.
  - If the slot carried a real instruction: ts[j] = slot_cnt (value before increment), j increments.
  - If it was a bubble: bubble_cnt increments. Re-evaluate ready_j in the next cycle.
- Multiple records with the same dst: wait for the latest producer (max). Duplicate records are harmless.
- Original NOP instructions (opcode 00) are issued as normal slots and count as spacing.
- After instruction 7 is accepted, go to DONE: done=1 for one cycle, busy=0, out_valid=0, then IDLE. bubble_cnt holds until the next start.
- Worst case: 7 chained dependencies, 14 bubbles, 22 slots < 2^SLOT_W.

Optional Feature:
- Macro HAZ_FORWARD_EN.
- Defined: the pipeline has EX/MEM forwarding. A dependency stalls only when the producer's opcode is lw (2'b11), with a required gap of 2 (one bubble when adjacent). All other dependencies need gap 1, i.e. no bubble.
- Undefined: every valid record uses GAP.

Decomposition:
- Package risc8_pkg:
  - Opcode constants: LW 2'b11, SW 2'b10, ADD 2'b01, NOOP 2'b00.
  - Register constants R0..R7.
  - HAZ_TAG_VALID 2'b01.
  - Record field offsets.
  - NOP_INSTR 8'h00.
  - Default GAP.
- Sub-module hazard_matrix: combinational unpack of hazard_bits into dep[8][8] with validity filtering. The sequencer instantiates it once on the registered list.

Test Plan:
- No hazards (hazard_bits=0), out_ready=1 → 8 instructions on 8 consecutive cycles starting start+2; bubble_cnt=0; done at cycle start+10.
- Record {0,1,01} only; I0=add r1,r2 (8'b01001010), I1=add r3,r1 → sequence I0,00,00,I1..I7; bubble_cnt=2.
- Record {0,2,01} → I0,I1,00,I2..I7; bubble_cnt=1. Records {0,1,01} and {1,2,01} → I0,00,00,I1,00,00,I2; bubble_cnt=4.
- out_ready deasserted 3 cycles during a bubble and during an instruction → outputs stable; sequence identical; no slot is lost or duplicated.
- Invalid records (tag 2'b10, dst<=src) → ignored; start while busy ignored; rst asserted mid-packet → out_valid=0 and busy=0 next cycle.
- HAZ_FORWARD_EN: I0=lw with {0,1,01} → one bubble. I0=add with {0,1,01} → zero bubbles.
